// File: rtl/pkt_channel_arbiter.sv
// pkt_channel_arbiter: round-robin, packet-granular arbiter
// sharing one head/tail-framed channel among N requesters.
module pkt_channel_arbiter #(
  parameter int N         = 4,
  parameter int W         = 32,
  parameter int MAX_BEATS = 64
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   req_valid,
  input  logic [N-1:0]   req_head,
  input  logic [N-1:0]   req_tail,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   req_ready,
  output logic           out_valid,
  output logic           out_head,
  output logic           out_tail,
  output logic [W-1:0]   out_data,
  input  logic           out_ready,
  output logic [N-1:0]   grant,
  output logic           busy,
  output logic           err_len
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_BEATS) + 1;

  typedef enum logic [1:0] {
    IDLE,
    LOCKED,
    DRAIN
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [N-1:0]  grant_d;
  logic [IW-1:0] own_q;
  logic [IW-1:0] own_d;
  logic [IW-1:0] rr_q;
  logic [IW-1:0] rr_d;
  logic [IW-1:0] own_nxt;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          err_d;
  logic          src_v;
  logic          src_h;
  logic          src_t;
  logic [W-1:0]  src_d;
  logic [IW-1:0] pick;
  logic          pick_ok;

  assign src_v   = req_valid[own_q];
  assign src_h   = req_head[own_q];
  assign src_t   = req_tail[own_q];
  assign src_d   = req_data[own_q*W +: W];
  assign own_nxt = (own_q == IW'(N-1)) ? '0 : own_q + IW'(1);
  assign busy    = (state_q != IDLE);

  // first head-bearing requester at or after rr_q, circularly
  always_comb begin
    int j;
    j       = 0;
    pick    = '0;
    pick_ok = 1'b0;
    for (int k = N-1; k >= 0; k--) begin
      j = int'(rr_q) + k;
      if (j >= N) j = j - N;
      if (req_valid[j] && req_head[j]) begin
        pick    = IW'(j);
        pick_ok = 1'b1;
      end
    end
  end

  // next state and channel muxing
  always_comb begin
    state_d   = state_q;
    grant_d   = grant;
    own_d     = own_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    req_ready = '0;
    out_valid = 1'b0;
    out_head  = 1'b0;
    out_tail  = 1'b0;
    out_data  = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_ok) begin
          state_d = LOCKED;
          grant_d = N'(1) << pick;
          own_d   = pick;
          cnt_d   = '0;
        end
      end
      LOCKED: begin
        out_valid = src_v;
        out_head  = src_h;
        out_tail  = src_t;
        out_data  = src_d;
        req_ready = grant & {N{out_ready}};
        if (src_v && out_ready) begin
          cnt_d = cnt_q + CW'(1);
          if (src_t) begin
            state_d = IDLE;
            grant_d = '0;
            rr_d    = own_nxt;
            cnt_d   = '0;
          end else if (cnt_q == CW'(MAX_BEATS-1)) begin
            err_d   = 1'b1;
            state_d = DRAIN;
            rr_d    = own_nxt;
          end
        end
      end
      DRAIN: begin
        req_ready = grant;
        if (src_v && src_t) begin
          state_d = IDLE;
          grant_d = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state register with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant   <= '0;
      own_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      err_len <= 1'b0;
    end else begin
      state_q <= state_d;
      grant   <= grant_d;
      own_q   <= own_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      err_len <= err_d;
    end
  end

endmodule

// File: tb/tb_pkt_channel_arbiter.sv
// tb_pkt_channel_arbiter: directed and randomized checks of
// pkt_channel_arbiter against a packet-level reference model.
module tb_pkt_channel_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_head;
  logic [N-1:0]   req_tail;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic           out_head;
  logic           out_tail;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic [N-1:0]   grant;
  logic           busy;
  logic           err_len;

  always #5 clk = ~clk;

  pkt_channel_arbiter #(.N(N), .W(W), .MAX_BEATS(MB)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_head(req_head),
    .req_tail(req_tail),
    .req_data(req_data),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_head(out_head),
    .out_tail(out_tail),
    .out_data(out_data),
    .out_ready(out_ready),
    .grant(grant),
    .busy(busy),
    .err_len(err_len)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, got, exp, $time);
    end
  endtask

  // reference model: packet owner, beats sent, rr start point
  int   m_own = -1;
  int   m_rr = 0;
  int   m_beats = 0;
  bit   m_drain = 1'b0;
  bit   m_err = 1'b0;
  int   n_own = -1;
  int   n_rr = 0;
  int   n_beats = 0;
  bit   n_drain = 1'b0;
  bit   n_err = 1'b0;
  bit   model_ok = 1'b0;
  logic [N-1:0] acc = '0;

  // compare DUT to model, then work out the model's next step
  always @(negedge clk) begin
    logic [N-1:0] eg;
    logic [N-1:0] er;
    logic         ev;
    int           j;
    bit           found;
    eg = (m_own < 0) ? '0 : (N'(1) << m_own);
    ev = 1'b0;
    er = '0;
    if (m_own >= 0) begin
      if (!m_drain) begin
        ev = req_valid[m_own];
        er = out_ready ? eg : '0;
      end else begin
        er = eg;
      end
    end
    acc = req_valid & er;
    if (model_ok) begin
      chk("grant", grant, eg);
      chk("busy", busy, m_own >= 0);
      chk("err_len", err_len, m_err);
      chk("out_valid", out_valid, ev);
      chk("req_ready", req_ready, er);
      if (ev) begin
        chk("out_head", out_head, req_head[m_own]);
        chk("out_tail", out_tail, req_tail[m_own]);
        chk("out_data", out_data, req_data[m_own*W +: W]);
      end
    end
    n_own   = m_own;
    n_rr    = m_rr;
    n_beats = m_beats;
    n_drain = m_drain;
    n_err   = 1'b0;
    if (!reset_n) begin
      n_own   = -1;
      n_rr    = 0;
      n_beats = 0;
      n_drain = 1'b0;
    end else if (m_own < 0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        j = (m_rr + k) % N;
        if (!found && req_valid[j] && req_head[j]) begin
          found   = 1'b1;
          n_own   = j;
          n_beats = 0;
          n_drain = 1'b0;
        end
      end
    end else if (!m_drain) begin
      if (ev && out_ready) begin
        n_beats = m_beats + 1;
        if (req_tail[m_own]) begin
          n_own   = -1;
          n_rr    = (m_own + 1) % N;
          n_beats = 0;
        end else if (n_beats == MB) begin
          n_err   = 1'b1;
          n_drain = 1'b1;
          n_rr    = (m_own + 1) % N;
        end
      end
    end else if (req_valid[m_own] && req_tail[m_own]) begin
      n_own   = -1;
      n_drain = 1'b0;
      n_beats = 0;
    end
  end

  // model state advances on the same edge as the DUT
  always @(posedge clk) begin
    m_own   <= n_own;
    m_rr    <= n_rr;
    m_beats <= n_beats;
    m_drain <= n_drain;
    m_err   <= n_err;
    if (!reset_n) model_ok <= 1'b1;
  end

  // protocol-following requesters
  int d_len[N];
  int d_idx[N];
  int d_pid[N];
  int vprob = 100;
  int newp = 0;
  int fix_len = 0;
  int or_mode = 0;
  bit auto_on = 1'b0;

  function automatic logic [W-1:0] bdata(int i, int p, int k);
    return {8'(i), 16'(p), 8'(k)};
  endfunction

  task automatic start_pkt(int i, int len);
    d_len[i] = len;
    d_idx[i] = 0;
    d_pid[i] = d_pid[i] + 1;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (d_len[i] > 0) begin
        req_valid[i] = int'($urandom_range(99)) < vprob;
        req_head[i]  = (d_idx[i] == 0);
        req_tail[i]  = (d_idx[i] == d_len[i] - 1);
        req_data[i*W +: W] = bdata(i, d_pid[i], d_idx[i]);
      end else begin
        req_valid[i] = 1'b0;
        req_head[i]  = 1'b0;
        req_tail[i]  = 1'b0;
        req_data[i*W +: W] = '0;
      end
    end
  endtask

  task automatic advance();
    for (int i = 0; i < N; i++) begin
      if (!reset_n) begin
        d_len[i] = 0;
      end else if (acc[i] && d_len[i] > 0) begin
        d_idx[i] = d_idx[i] + 1;
        if (d_idx[i] == d_len[i]) d_len[i] = 0;
      end
      if (auto_on && reset_n && d_len[i] == 0 &&
          int'($urandom_range(99)) < newp)
        start_pkt(i, fix_len > 0 ? fix_len
                                 : int'($urandom_range(6, 1)));
    end
    case (or_mode)
      0: out_ready = 1'b1;
      1: out_ready = ~out_ready;
      default: out_ready = ($urandom_range(3) != 0);
    endcase
  endtask

  logic [N-1:0] r_g[64];
  logic [N-1:0] r_rdy[64];
  logic [W-1:0] r_dat[64];
  logic         r_ov[64];
  logic         r_err[64];
  logic         r_busy[64];
  logic         r_h[64];
  logic         r_t[64];
  logic         r_xf[64];

  task automatic run(int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k < 64) begin
        r_g[k]    = grant;
        r_rdy[k]  = req_ready;
        r_dat[k]  = out_data;
        r_ov[k]   = out_valid;
        r_err[k]  = err_len;
        r_busy[k] = busy;
        r_h[k]    = out_head;
        r_t[k]    = out_tail;
        r_xf[k]   = out_valid & out_ready;
      end
      @(posedge clk);
      #1;
      advance();
      drive();
    end
  endtask

  // nibble sequence, first cycle in the leftmost digit
  task automatic chk_n(string nm, int n, logic [63:0] exp, int sel);
    logic [3:0] e;
    for (int k = 0; k < n; k++) begin
      e = exp[(n-1-k)*4 +: 4];
      if (sel == 0) chk($sformatf("%s_grant[%0d]", nm, k), r_g[k], e);
      else chk($sformatf("%s_ready[%0d]", nm, k), r_rdy[k], e);
    end
  endtask

  // bit sequence, first cycle in the leftmost bit
  task automatic chk_b(string nm, int n, logic [63:0] exp, int sel);
    logic g;
    for (int k = 0; k < n; k++) begin
      case (sel)
        0: g = r_ov[k];
        1: g = r_err[k];
        2: g = r_busy[k];
        3: g = r_h[k];
        default: g = r_t[k];
      endcase
      chk($sformatf("%s_s%0d[%0d]", nm, sel, k), g, exp[n-1-k]);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    auto_on = 1'b0;
    or_mode = 0;
    vprob   = 100;
    for (int i = 0; i < N; i++) d_len[i] = 0;
    drive();
    run(2);
    reset_n = 1'b1;
  endtask

  initial begin
    int p;
    int nx;
    reset_n   = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      d_len[i] = 0;
      d_idx[i] = 0;
      d_pid[i] = 0;
    end
    drive();

    // single 3-beat packet on req0
    do_reset();
    start_pkt(0, 3);
    p = d_pid[0];
    drive();
    run(5);
    chk_n("t1", 5, 64'h01110, 0);
    chk_b("t1", 5, 64'b01110, 0);
    chk_b("t1", 5, 64'b01000, 3);
    chk_b("t1", 5, 64'b00010, 4);
    for (int k = 0; k < 3; k++)
      chk($sformatf("t1_data%0d", k), r_dat[k+1], bdata(0, p, k));

    // round robin, 2-beat packets from everyone
    do_reset();
    auto_on = 1'b1;
    fix_len = 2;
    newp    = 100;
    for (int i = 0; i < N; i++) start_pkt(i, 2);
    drive();
    run(14);
    chk_n("t2", 14, 64'h01102204408801, 0);
    auto_on = 1'b0;
    run(20);

    // backpressure with out_ready toggling
    do_reset();
    start_pkt(1, 4);
    p = d_pid[1];
    out_ready = 1'b1;
    or_mode   = 1;
    drive();
    run(10);
    chk_n("t3", 10, 64'h0020202020, 1);
    nx = 0;
    for (int k = 0; k < 10; k++) begin
      if (r_xf[k]) begin
        chk($sformatf("t3_beat%0d", nx), r_dat[k], bdata(1, p, nx));
        nx++;
      end
    end
    chk("t3_nbeats", nx, 4);
    or_mode = 0;

    // 6-beat packet on req2 overflows MAX_BEATS=4
    do_reset();
    start_pkt(2, 6);
    drive();
    run(8);
    chk_n("t4", 8, 64'h04444440, 0);
    chk_n("t4", 8, 64'h04444440, 1);
    chk_b("t4", 8, 64'b01111000, 0);
    chk_b("t4", 8, 64'b00000100, 1);
    chk_b("t4", 8, 64'b01111110, 2);
    chk("t4_model_rr", m_rr, 3);
    start_pkt(0, 1);
    start_pkt(3, 1);
    drive();
    run(5);
    chk_n("t4rr", 5, 64'h08010, 0);
    chk("t4rr_model_rr", m_rr, 1);

    // reset during beat 2 of a 5-beat packet from req1
    start_pkt(1, 5);
    drive();
    run(2);
    chk_n("t5a", 2, 64'h02, 0);
    reset_n = 1'b0;
    run(1);
    chk_b("t5b", 1, 64'b1, 0);
    reset_n = 1'b1;
    run(1);
    chk_n("t5c", 1, 64'h0, 0);
    chk_b("t5c", 1, 64'b0, 0);
    chk_b("t5c", 1, 64'b0, 2);
    chk("t5_model_rr", m_rr, 0);
    start_pkt(0, 1);
    start_pkt(1, 1);
    drive();
    run(3);
    chk_n("t5d", 3, 64'h010, 0);

    // single-beat packets on req1 and req3 with rr at 2
    do_reset();
    start_pkt(1, 1);
    drive();
    run(3);
    chk_n("t6a", 3, 64'h020, 0);
    start_pkt(1, 1);
    start_pkt(3, 1);
    drive();
    run(5);
    chk_n("t6", 5, 64'h08020, 0);
    chk_b("t6", 5, 64'b01010, 0);
    chk_b("t6", 5, 64'b01010, 3);
    chk_b("t6", 5, 64'b01010, 4);

    // randomized traffic, stalls, overflows and resets
    do_reset();
    auto_on = 1'b1;
    fix_len = 0;
    newp    = 30;
    vprob   = 80;
    or_mode = 2;
    for (int c = 0; c < 4000; c++) begin
      reset_n = ($urandom_range(299) != 0);
      run(1);
    end
    reset_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
